// File: rtl/reg_to_wide_vr.sv
// rtl/reg_to_wide_vr.sv - assembles a DATA_W word from 32-bit register writes and commits it to a valid/ready output
module reg_to_wide_vr #(
  parameter int ADDRWIDTH = 12,
  parameter int DATA_W    = 512,
  parameter int ID_W      = 6
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  input  logic [ADDRWIDTH-1:0] addr,
  input  logic                 read_en,
  input  logic                 write_en,
  input  logic [3:0]           byte_strobe,
  input  logic [31:0]          wdata,
  output logic [31:0]          rdata,
  output logic [DATA_W-1:0]    data_out,
  output logic [ID_W-1:0]      data_out_id,
  output logic                 data_out_last,
  output logic                 data_out_valid,
  input  logic                 data_out_ready
);

  localparam int NWORDS = DATA_W / 32;
  localparam int IDX_W  = ADDRWIDTH - 2;
  localparam logic [IDX_W-1:0] CTRL_IDX   = IDX_W'(32'h800 >> 2);
  localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(32'h804 >> 2);

  logic [DATA_W-1:0] asm_q, asm_d, asm_wr;
  logic [NWORDS-1:0] mask_q, mask_d, mask_wr;
  logic [ID_W-1:0]   id_cnt_q, id_cnt_d;
  logic              ovf_q, ovf_d;
  logic              auto_q, auto_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic [ID_W-1:0]   dout_id_q, dout_id_d;
  logic              dout_last_q, dout_last_d;
  logic              dout_valid_q, dout_valid_d;

  logic [IDX_W-1:0] idx;
  logic data_hit, ctrl_hit, status_hit;
  logic commit_req, commit_last, drain, accept, clear;
  logic [7:0] pop_cnt;

  assign idx        = addr[ADDRWIDTH-1:2];
  assign data_hit   = idx < IDX_W'(NWORDS);
  assign ctrl_hit   = idx == CTRL_IDX;
  assign status_hit = idx == STATUS_IDX;

  // Auto-commit fires on the last word so the committed word includes that write.
  assign commit_req  = write_en & ((ctrl_hit & wdata[0]) | (auto_q & (idx == IDX_W'(NWORDS - 1))));
  assign commit_last = ctrl_hit & wdata[1];
  assign drain       = dout_valid_q & data_out_ready;
  assign accept      = commit_req & (~dout_valid_q | drain);
  assign clear       = write_en & ctrl_hit & wdata[2];

  always_comb begin
    asm_wr  = asm_q;
    mask_wr = mask_q;
    if (write_en && data_hit) begin
      for (int k = 0; k < NWORDS; k++) begin
        if (idx == IDX_W'(k)) begin
          for (int b = 0; b < 4; b++) begin
            if (byte_strobe[b]) begin
              asm_wr[32*k + 8*b +: 8] = wdata[8*b +: 8];
              mask_wr[k]              = 1'b1;
            end
          end
        end
      end
    end
  end

  always_comb begin
    asm_d        = asm_wr;
    mask_d       = mask_wr;
    id_cnt_d     = id_cnt_q;
    ovf_d        = ovf_q;
    auto_d       = auto_q;
    dout_d       = dout_q;
    dout_id_d    = dout_id_q;
    dout_last_d  = dout_last_q;
    dout_valid_d = dout_valid_q & ~drain;
    if (accept) begin
      dout_d       = asm_wr;
      dout_id_d    = id_cnt_q;
      dout_last_d  = commit_last;
      dout_valid_d = 1'b1;
      mask_d       = '0;
      id_cnt_d     = commit_last ? '0 : id_cnt_q + ID_W'(1);
    end else if (commit_req) begin
      ovf_d = 1'b1;
    end
    if (write_en && status_hit && wdata[1]) ovf_d = 1'b0;
    if (write_en && ctrl_hit && byte_strobe[0]) auto_d = wdata[3];
    // Clear is applied after commit so a combined write commits the old contents.
    if (clear) begin
      asm_d    = '0;
      mask_d   = '0;
      id_cnt_d = '0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      asm_q        <= '0;
      mask_q       <= '0;
      id_cnt_q     <= '0;
      ovf_q        <= 1'b0;
      auto_q       <= 1'b0;
      dout_q       <= '0;
      dout_id_q    <= '0;
      dout_last_q  <= 1'b0;
      dout_valid_q <= 1'b0;
    end else begin
      asm_q        <= asm_d;
      mask_q       <= mask_d;
      id_cnt_q     <= id_cnt_d;
      ovf_q        <= ovf_d;
      auto_q       <= auto_d;
      dout_q       <= dout_d;
      dout_id_q    <= dout_id_d;
      dout_last_q  <= dout_last_d;
      dout_valid_q <= dout_valid_d;
    end
  end

  always_comb begin
    pop_cnt = '0;
    for (int k = 0; k < NWORDS; k++) pop_cnt = pop_cnt + 8'(mask_q[k]);
  end

  always_comb begin
    rdata = '0;
    if (read_en) begin
      if (data_hit) begin
        for (int k = 0; k < NWORDS; k++)
          if (idx == IDX_W'(k)) rdata = asm_q[32*k +: 32];
      end else if (ctrl_hit) begin
        rdata = {28'b0, auto_q, 3'b0};
      end else if (status_hit) begin
        rdata = {8'b0, pop_cnt, 8'(id_cnt_q), 6'b0, ovf_q, dout_valid_q};
      end
    end
  end

  assign data_out       = dout_q;
  assign data_out_id    = dout_id_q;
  assign data_out_last  = dout_last_q;
  assign data_out_valid = dout_valid_q;

endmodule

// File: tb/tb_reg_to_wide_vr.sv
// tb/tb_reg_to_wide_vr.sv - randomized self-checking bench for reg_to_wide_vr
module tb_reg_to_wide_vr;

  localparam int AW = 12;
  localparam int DW = 512;
  localparam int IW = 2;
  localparam int NW = DW / 32;

  logic          hclk = 1'b0;
  logic          hresetn;
  logic [AW-1:0] addr;
  logic          read_en, write_en;
  logic [3:0]    byte_strobe;
  logic [31:0]   wdata, rdata;
  logic [DW-1:0] data_out;
  logic [IW-1:0] data_out_id;
  logic          data_out_last, data_out_valid, data_out_ready;

  reg_to_wide_vr #(.ADDRWIDTH(AW), .DATA_W(DW), .ID_W(IW)) dut (
    .hclk(hclk), .hresetn(hresetn), .addr(addr), .read_en(read_en), .write_en(write_en),
    .byte_strobe(byte_strobe), .wdata(wdata), .rdata(rdata), .data_out(data_out),
    .data_out_id(data_out_id), .data_out_last(data_out_last), .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready)
  );

  always #5 hclk = ~hclk;

  int n_tests = 0;
  int n_fail  = 0;

  bit [31:0]     m_buf [NW];
  bit            m_mask[NW];
  int            m_id;
  bit            m_ovf, m_auto, m_valid, m_last;
  logic [DW-1:0] m_out;
  int            m_oid;

  task automatic check(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NW; k++) begin
      m_buf[k]  = '0;
      m_mask[k] = 1'b0;
    end
    m_id = 0; m_ovf = 0; m_auto = 0; m_valid = 0; m_last = 0; m_out = '0; m_oid = 0;
  endtask

  function automatic logic [31:0] model_read(input logic [AW-1:0] a);
    int w;
    int cnt;
    w = int'(a >> 2);
    cnt = 0;
    for (int k = 0; k < NW; k++) cnt += int'(m_mask[k]);
    if (w < NW) return m_buf[w];
    if (w == 'h200) return {28'd0, m_auto, 3'd0};
    if (w == 'h201) return {8'd0, 8'(cnt), 8'(m_id), 6'd0, m_ovf, m_valid};
    return 32'd0;
  endfunction

  task automatic model_step();
    int  w;
    bit  commit, last, drain, accept;
    w      = int'(addr >> 2);
    commit = 0;
    last   = 0;
    drain  = m_valid && data_out_ready;
    if (write_en && w < NW) begin
      for (int b = 0; b < 4; b++)
        if (byte_strobe[b]) begin
          m_buf[w][8*b +: 8] = wdata[8*b +: 8];
          m_mask[w] = 1'b1;
        end
    end
    if (write_en && w == 'h200) begin
      commit = wdata[0];
      last   = wdata[1];
    end
    if (write_en && m_auto && w == NW - 1) commit = 1;
    accept = commit && (!m_valid || drain);
    if (drain) m_valid = 0;
    if (accept) begin
      for (int k = 0; k < NW; k++) begin
        m_out[32*k +: 32] = m_buf[k];
        m_mask[k] = 1'b0;
      end
      m_oid   = m_id;
      m_last  = last;
      m_valid = 1;
      m_id    = last ? 0 : (m_id + 1) % (1 << IW);
    end else if (commit) begin
      m_ovf = 1;
    end
    if (write_en && w == 'h201 && wdata[1]) m_ovf = 0;
    if (write_en && w == 'h200 && byte_strobe[0]) m_auto = wdata[3];
    if (write_en && w == 'h200 && wdata[2]) begin
      for (int k = 0; k < NW; k++) begin
        m_buf[k]  = '0;
        m_mask[k] = 1'b0;
      end
      m_id  = 0;
      m_ovf = 0;
    end
  endtask

  task automatic check_outputs();
    check("valid", DW'(data_out_valid), DW'(m_valid));
    if (m_valid) begin
      check("data", data_out, m_out);
      check("id", DW'(data_out_id), DW'(m_oid));
      check("last", DW'(data_out_last), DW'(m_last));
    end
  endtask

  // op: 0 idle, 1 write, 2 read. Starts just after a rising edge.
  task automatic bus(input int op, input logic [AW-1:0] a, input logic [3:0] st,
                     input logic [31:0] wd, input logic rdy, output logic [31:0] rd);
    addr = a; read_en = (op == 2); write_en = (op == 1);
    byte_strobe = st; wdata = wd; data_out_ready = rdy;
    #3;
    rd = rdata;
    check("rdata", DW'(rd), DW'((op == 2) ? model_read(a) : 32'd0));
    @(posedge hclk);
    model_step();
    #1;
    check_outputs();
    read_en = 0; write_en = 0;
  endtask

  logic [31:0] rd;

  initial begin
    hresetn = 0; addr = '0; read_en = 0; write_en = 0; byte_strobe = '0; wdata = '0;
    data_out_ready = 0;
    model_reset();
    repeat (2) @(posedge hclk);
    #1;
    check("rst_valid", DW'(data_out_valid), '0);
    check("rst_data", data_out, '0);
    check("rst_id", DW'(data_out_id), '0);
    check("rst_last", DW'(data_out_last), '0);
    check("rst_rdata", DW'(rdata), '0);
    @(negedge hclk); hresetn = 1;
    @(posedge hclk); #1;
    bus(2, 12'h804, 4'hF, 0, 0, rd);

    for (int k = 0; k < NW; k++) bus(1, AW'(4 * k), 4'hF, 32'h1000_0000 + k, 0, rd);
    bus(1, 12'h800, 4'hF, 32'h1, 0, rd);
    check("commit_lo", DW'(data_out[31:0]), DW'(32'h1000_0000));
    check("commit_hi", DW'(data_out[511:480]), DW'(32'h1000_000F));
    check("commit_id", DW'(data_out_id), '0);
    check("commit_valid", DW'(data_out_valid), DW'(1));
    bus(0, 0, 0, 0, 1, rd);
    check("drained", DW'(data_out_valid), '0);
    bus(2, 12'h804, 4'hF, 0, 1, rd);
    check("status_id1", DW'(rd[15:8]), DW'(1));

    bus(1, 12'h008, 4'hF, 32'hAABB_CCDD, 0, rd);
    bus(1, 12'h008, 4'b0101, 32'h1122_3344, 0, rd);
    bus(2, 12'h008, 4'hF, 0, 0, rd);
    check("strobe_word", DW'(rd), DW'(32'hAA22_CC44));
    bus(2, 12'h804, 4'hF, 0, 0, rd);
    check("strobe_cnt", DW'(rd[23:16]), DW'(1));

    bus(1, 12'h800, 4'hF, 32'h4, 0, rd);
    bus(1, 12'h000, 4'hF, 32'hA5A5_0001, 0, rd);
    bus(1, 12'h800, 4'hF, 32'h1, 0, rd);
    bus(1, 12'h000, 4'h0, 32'h0, 0, rd);
    bus(1, 12'h800, 4'hF, 32'h1, 0, rd);
    bus(2, 12'h804, 4'hF, 0, 0, rd);
    check("bp_status", DW'(rd), DW'(32'h0000_0103));
    check("bp_hold_id", DW'(data_out_id), '0);
    check("bp_hold_data", DW'(data_out[31:0]), DW'(32'hA5A5_0001));
    bus(1, 12'h804, 4'hF, 32'h2, 0, rd);
    bus(2, 12'h804, 4'hF, 0, 0, rd);
    check("w1c_status", DW'(rd), DW'(32'h0000_0101));

    bus(1, 12'h800, 4'hF, 32'hC, 1, rd);
    for (int p = 0; p < 2; p++) begin
      for (int k = 0; k < NW; k++) bus(1, AW'(4 * k), 4'hF, $urandom, 1, rd);
      check("auto_valid", DW'(data_out_valid), DW'(1));
      check("auto_id", DW'(data_out_id), DW'(p));
    end
    bus(1, 12'h800, 4'hF, 32'hB, 1, rd);
    check("auto_last", DW'(data_out_last), DW'(1));
    bus(2, 12'h804, 4'hF, 0, 1, rd);
    check("last_id_reset", DW'(rd[15:8]), '0);

    bus(1, 12'h800, 4'hF, 32'h4, 1, rd);
    for (int i = 0; i < 5; i++) begin
      bus(1, 12'h800, 4'hF, 32'h1, 1, rd);
      check("wrap_id", DW'(data_out_id), DW'(i % 4));
      check("wrap_valid", DW'(data_out_valid), DW'(1));
    end
    bus(2, 12'h804, 4'hF, 0, 0, rd);
    check("no_ovf", DW'(rd[1]), '0);

    for (int i = 0; i < 600; i++) begin
      int sel;
      logic [AW-1:0] a;
      logic [31:0]   d;
      sel = $urandom_range(0, 9);
      d   = $urandom;
      if (sel <= 5) a = AW'(4 * $urandom_range(0, NW - 1));
      else if (sel == 6) begin
        a = 12'h800;
        if ($urandom_range(0, 3) != 0) d[2] = 1'b0;
      end else if (sel == 7) a = 12'h804;
      else if (sel == 8) a = 12'h040;
      else a = 12'h900;
      bus($urandom_range(0, 2), a, 4'($urandom_range(0, 15)), d, 1'($urandom_range(0, 1)), rd);
    end

    bus(0, 0, 0, 0, 1, rd);
    bus(1, 12'h004, 4'hF, 32'h5555_AAAA, 0, rd);
    bus(1, 12'h800, 4'hF, 32'h1, 0, rd);
    check("pre_rst_valid", DW'(data_out_valid), DW'(1));
    #2 hresetn = 0;
    #1;
    model_reset();
    check("mid_rst_valid", DW'(data_out_valid), '0);
    check("mid_rst_data", data_out, '0);
    check("mid_rst_id", DW'(data_out_id), '0);
    check("mid_rst_last", DW'(data_out_last), '0);
    @(negedge hclk); hresetn = 1;
    @(posedge hclk); #1;
    bus(2, 12'h004, 4'hF, 0, 0, rd);
    bus(2, 12'h800, 4'hF, 0, 0, rd);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
